// File: rtl/axi_full_pkg.sv
// Shared constants and state types for the AXI4-full memory subordinate.
package axi_full_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

endpackage

// File: rtl/axi_sub_ram.sv
// Word memory: one byte-enabled write port, one registered read port.
// A read and a write to the same word in one cycle return the old contents.
module axi_sub_ram #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic                    re,
  input  logic [ADDR_W-1:0]       raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (wbe[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Only the output register is reset; the array contents survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axi_full_subordinate_mem.sv
// AXI4-full INCR-burst subordinate over an on-chip word memory, independent read/write engines.
// Define S_AXI_WSTRB_EN to honour WSTRB byte lanes; otherwise every beat writes the full word.
module axi_full_subordinate_mem
  import axi_full_pkg::*;
#(
  parameter int unsigned S_AXI_DATA_WIDTH = 64,
  parameter int unsigned S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned S_AXI_ID_WIDTH   = 1,
  parameter int unsigned MEM_DEPTH        = 256
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY
);

  localparam int unsigned STRB_W = S_AXI_DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [S_AXI_ID_WIDTH-1:0] wr_id;
  logic [IDX_W-1:0]          wr_addr;
  logic [7:0]                wr_len;
  logic [7:0]                wr_cnt;
  logic                      wr_err;

  logic [S_AXI_ID_WIDTH-1:0] rd_id;
  logic [IDX_W-1:0]          rd_addr;
  logic [7:0]                rd_len;
  logic [7:0]                rd_cnt;

  logic awready, wready, bvalid, aw_hs, w_hs;
  logic arready, rvalid, rlast, ar_hs, r_hs;

  logic                ram_we, ram_re;
  logic [IDX_W-1:0]    ram_raddr;
  logic [STRB_W-1:0]   ram_be;
  logic                unused_bits;

  // ---------------- write engine ----------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state <= WR_IDLE;
    end else begin
      wr_state <= wr_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        awready = S_AXI_ARESETN;
        if (S_AXI_AWVALID && S_AXI_ARESETN) wr_next = WR_DATA;
      end
      WR_DATA: begin
        wready = 1'b1;
        if (S_AXI_WVALID && (wr_cnt == wr_len)) wr_next = WR_RESP;
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (S_AXI_BREADY) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  assign aw_hs = awready & S_AXI_AWVALID;
  assign w_hs  = wready & S_AXI_WVALID;

  // Burst length is taken from AWLEN; WLAST is only checked against it.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_id   <= '0;
      wr_addr <= '0;
      wr_len  <= '0;
      wr_cnt  <= '0;
      wr_err  <= 1'b0;
    end else if (aw_hs) begin
      wr_id   <= S_AXI_AWID;
      wr_addr <= S_AXI_AWADDR[OFF_W +: IDX_W];
      wr_len  <= S_AXI_AWLEN;
      wr_cnt  <= '0;
      wr_err  <= 1'b0;
    end else if (w_hs) begin
      wr_addr <= wr_addr + IDX_W'(1);
      wr_cnt  <= wr_cnt + 8'd1;
      if (S_AXI_WLAST != (wr_cnt == wr_len)) wr_err <= 1'b1;
    end
  end

  assign ram_we = w_hs;

`ifdef S_AXI_WSTRB_EN
  assign ram_be      = S_AXI_WSTRB;
  assign unused_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};
`else
  assign ram_be      = '1;
  assign unused_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WSTRB};
`endif

  // ---------------- read engine ----------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state <= RD_IDLE;
    end else begin
      rd_state <= rd_next;
    end
  end

  assign rlast = (rd_state == RD_DATA) && (rd_cnt == rd_len);

  always_comb begin
    rd_next = rd_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        arready = S_AXI_ARESETN;
        if (S_AXI_ARVALID && S_AXI_ARESETN) rd_next = RD_DATA;
      end
      RD_DATA: begin
        rvalid = 1'b1;
        if (S_AXI_RREADY && rlast) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  assign ar_hs = arready & S_AXI_ARVALID;
  assign r_hs  = rvalid & S_AXI_RREADY;

  // The RAM output register is the RDATA register: it only loads on AR
  // handshake (first beat) or on a non-final R handshake (next beat), so it
  // holds steady while the manager stalls.
  assign ram_re    = ar_hs | (r_hs & ~rlast);
  assign ram_raddr = ar_hs ? S_AXI_ARADDR[OFF_W +: IDX_W] : rd_addr + IDX_W'(1);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_id   <= '0;
      rd_addr <= '0;
      rd_len  <= '0;
      rd_cnt  <= '0;
    end else if (ar_hs) begin
      rd_id   <= S_AXI_ARID;
      rd_addr <= S_AXI_ARADDR[OFF_W +: IDX_W];
      rd_len  <= S_AXI_ARLEN;
      rd_cnt  <= '0;
    end else if (r_hs && !rlast) begin
      rd_addr <= rd_addr + IDX_W'(1);
      rd_cnt  <= rd_cnt + 8'd1;
    end
  end

  axi_sub_ram #(
    .DATA_WIDTH (S_AXI_DATA_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .ADDR_W     (IDX_W)
  ) u_ram (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (S_AXI_WDATA),
    .wbe   (ram_be),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (S_AXI_RDATA)
  );

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BID     = wr_id;
  assign S_AXI_BRESP   = wr_err ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RLAST   = rlast;
  assign S_AXI_RID     = rd_id;
  assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_axi_full_subordinate_mem.sv
// Bench for axi_full_subordinate_mem: table of write bursts each read back through a scoreboard queue.
module tb_axi_full_subordinate_mem;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 32;
  localparam int unsigned IW    = 1;
  localparam int unsigned DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] awid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_full_subordinate_mem #(
    .S_AXI_DATA_WIDTH (DW),
    .S_AXI_ADDR_WIDTH (AW),
    .S_AXI_ID_WIDTH   (IW),
    .MEM_DEPTH        (DEPTH)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWID    (awid),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWLEN   (awlen),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WLAST   (wlast),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BID     (bid),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARID    (arid),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARLEN   (arlen),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RID     (rid),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RLAST   (rlast),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [IW-1:0] id;
    logic [DW-1:0] base;      // beat i carries base + i
    int            err_beat;  // beat index that raises WLAST early, -1 for none
    logic [7:0]    strb;
    bit            toggle;    // read back with RREADY alternating 1/0
    logic [1:0]    bresp;     // expected write response
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [IW-1:0] id;
  } exp_t;

  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;
  logic [DW-1:0] model [DEPTH];
  exp_t          sb [$];
  vec_t          vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_write(input int unsigned idx, input logic [DW-1:0] d, input logic [7:0] s);
`ifdef S_AXI_WSTRB_EN
    for (int b = 0; b < DW/8; b++) begin
      if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
    end
`else
    if (s == s) model[idx] = d;
`endif
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctl"},
          {52'd0, awready, wready, bvalid, bresp, bid, arready, rvalid, rlast, rresp, rid},
          64'd0);
    check({name, "_rdata"}, rdata, 64'd0);
  endtask

  task automatic do_write(input vec_t v);
    int unsigned w = (v.addr >> 3) % DEPTH;
    int guard;
    @(posedge clk); #1;
    awid = v.id; awaddr = v.addr; awlen = v.len; awvalid = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!awready && guard < 50);
    check("aw_ready", {63'd0, awready}, 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(v.len); i++) begin
      wdata  = v.base + DW'(i);
      wstrb  = v.strb;
      wlast  = (i == int'(v.len)) ^ (i == v.err_beat);
      wvalid = 1'b1;
      guard  = 0;
      do begin @(negedge clk); guard++; end while (!wready && guard < 50);
      check("w_ready", {63'd0, wready}, 64'd1);
      model_write((w + i) % DEPTH, wdata, wstrb);
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    @(negedge clk);
    check("bvalid_latency", {63'd0, bvalid}, 64'd1);
    check("bresp", {62'd0, bresp}, {62'd0, v.bresp});
    check("bid", {63'd0, bid}, {63'd0, v.id});
    @(posedge clk); #1;
    @(negedge clk);
    check("b_done", {62'd0, bvalid, awready}, 64'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [IW-1:0] id, input bit toggle);
    int unsigned w = (addr >> 3) % DEPTH;
    int popped = 0;
    int cyc = 0;
    int guard;
    exp_t e;
    for (int i = 0; i <= int'(len); i++) begin
      sb.push_back('{model[(w + i) % DEPTH], (i == int'(len)), id});
    end
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1; rready = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!arready && guard < 50);
    check("ar_ready", {63'd0, arready}, 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("rvalid_latency", {63'd0, rvalid}, 64'd1);
    while (popped <= int'(len) && cyc < 200) begin
      if (rvalid && sb.size() > 0) begin
        e = sb[0];
        check("rdata", rdata, e.data);
        check("rlast", {63'd0, rlast}, {63'd0, e.last});
        check("rid", {63'd0, rid}, {63'd0, e.id});
        if (rready) begin
          void'(sb.pop_front());
          popped++;
        end
      end
      @(posedge clk); #1;
      cyc++;
      rready = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
    end
    rready = 1'b1;
    check("r_beats", 64'(popped), 64'(int'(len) + 1));
    check("rvalid_after_last", {63'd0, rvalid}, 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b1;

    vecs[0] = '{32'h0000_0000, 8'd3, 1'b1, 64'd1,                   -1, 8'hFF, 1'b0, 2'b00};
    vecs[1] = '{32'h0000_0100, 8'd7, 1'b0, 64'h1000,                -1, 8'hFF, 1'b1, 2'b00};
    vecs[2] = '{32'h0000_0200, 8'd3, 1'b1, 64'h2000,                 1, 8'hFF, 1'b0, 2'b10};
    vecs[3] = '{32'h0000_0300, 8'd3, 1'b0, 64'h3000,                -1, 8'hFF, 1'b0, 2'b00};
    vecs[4] = '{32'h0000_07F8, 8'd1, 1'b1, 64'h7000,                -1, 8'hFF, 1'b0, 2'b00};
    vecs[5] = '{32'hFFFF_F808, 8'd0, 1'b1, 64'h5000,                -1, 8'hFF, 1'b0, 2'b00};
    vecs[6] = '{32'h0000_0040, 8'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, -1, 8'hFF, 1'b0, 2'b00};
    vecs[7] = '{32'h0000_0040, 8'd0, 1'b0, 64'h0,                  -1, 8'h0F, 1'b0, 2'b00};
    vecs[8] = '{32'h0000_0400, 8'd3, 1'b0, 64'hA0,                 -1, 8'hFF, 1'b0, 2'b00};

    #2;
    check_reset_outputs("reset_initial");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {62'd0, awready, arready}, 64'd3);

    foreach (vecs[k]) begin
      do_write(vecs[k]);
      do_read(vecs[k].addr, vecs[k].len, vecs[k].id, vecs[k].toggle);
    end

    // The wrapped second beat of the 0x7F8 burst must sit at word 0.
    do_read(32'h0000_0000, 8'd0, 1'b0, 1'b0);
    check("wrap_word0", model[0], 64'h7001);

    // Reset during beat 2 of a 4-beat write over the 0xA0.. words.
    @(posedge clk); #1;
    awid = 1'b1; awaddr = 32'h400; awlen = 8'd3; awvalid = 1'b1;
    @(negedge clk);
    check("mid_aw_ready", {63'd0, awready}, 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wdata = 64'hB0; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
    @(negedge clk);
    check("mid_w1_ready", {63'd0, wready}, 64'd1);
    model_write(32'h80, 64'hB0, 8'hFF);
    @(posedge clk); #1;
    wdata = 64'hB1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_burst");
    wvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", {61'd0, awready, wready, arready}, 64'b101);
    do_read(32'h0000_0400, 8'd3, 1'b0, 1'b0);
    check("mid_model_words", {model[16'h80][7:0], model[16'h81][7:0], model[16'h83][7:0]},
          64'hB0A1A3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

endmodule
